pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and instruction-memory fetch for the RV32I core.
- Owns the PC register, issues one outstanding fetch at a time on a req/gnt/rvalid handshake, and presents instructions to decode on a valid/ready handshake.
- Applies trap, redirect (branch/jump), halt and fetch-timeout events with fixed priority.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap, misaligned redirect or fetch timeout.
- MAX_WAIT, 8, max cycles in WAIT without rvalid before a fetch fault; range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals pc_o while imem_req_o is high.
- imem_gnt_i  in  1  memory accepted request this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- instr_valid_o  out  1  instruction available to decode.
- instr_o  out  32  instruction word.
- instr_pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  decode accepts instruction.
- redirect_i  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- trap_i  in  1  exception request; single-cycle pulse.
- halt_i  in  1  level; stop fetching while high.
- fetch_fault_o  out  1  one-cycle pulse on misaligned redirect or timeout.
- pc_o  out  32  current PC register.

Behaviour:
- Reset (async assert):
  - pc_o = RESET_VEC; state = BOOT.
  - imem_req_o, instr_valid_o, fetch_fault_o = 0; instr_o, instr_pc_o = 0; wait counter = 0.
  - Deassertion is used synchronously; the first request is issued in the cycle after BOOT.
- States:
  - BOOT: go to REQ after one cycle.
  - REQ: imem_req_o=1, imem_addr_o=pc_o. If imem_gnt_i, go to WAIT and clear the counter; otherwise stay.
  - WAIT: imem_req_o=0; counter increments each cycle. On imem_rvalid_i, latch instr_o=imem_rdata_i and instr_pc_o=pc_o, then go to HOLD. instr_valid_o is high from the next cycle, so grant-to-valid latency is at least 2 cycles.
  - HOLD: instr_valid_o=1 and outputs stable. On instr_ready_i, pc_o <= pc_o+4 (wraps modulo 2^32) and go to REQ. A back-to-back fetch therefore costs at least 3 cycles.
  - DRAIN: an outstanding response must be discarded. Wait for imem_rvalid_i (data dropped, instr_valid_o stays 0), then go to REQ. The timeout counter also runs here.
  - HALTED: no requests. Leave to REQ when halt_i is 0.
- Event priority, evaluated every cycle in every state except BOOT: trap_i > redirect_i > timeout > halt_i > normal transition.
  - Trap: pc_o <= TRAP_VEC.
  - Redirect:
    - If redirect_pc_i[1:0] != 0: treat as fault, pc_o <= TRAP_VEC, fetch_fault_o pulses next cycle.
    - Otherwise pc_o <= redirect_pc_i.
  - Next state after trap or redirect:
    - from WAIT (without rvalid the same cycle) → DRAIN.
    - from REQ with gnt the same cycle → DRAIN.
    - else → REQ.
    - instr_valid_o drops the next cycle; a held instruction is flushed even if instr_ready_i is high the same cycle.
  - Timeout: counter == MAX_WAIT in WAIT with no rvalid. fetch_fault_o pulses, pc_o <= TRAP_VEC, go to DRAIN. In DRAIN the timeout is not re-armed; DRAIN waits indefinitely for rvalid.
  - Halt:
    - HOLD: the instruction completes its handshake first; if instr_ready_i, PC advances, then go to HALTED.
    - REQ: abort the request only if gnt is not also high (gnt high → go to WAIT).
    - WAIT/DRAIN: the response completes first.
- imem_req_o never drops in REQ before gnt except on trap, redirect or halt.
- At most one outstanding transaction at any time.
- A stray rvalid in REQ, HOLD, HALTED or BOOT is ignored.

Test Plan:
- Reset, gnt tied high, rvalid one cycle after gnt, ready high → addresses 0x0, 0x4, 0x8 issued every 3 cycles; instr_pc_o matches each address; instr_o equals the returned data.
- In HOLD with instr_ready_i=0 for 5 cycles → instr_valid_o, instr_o and instr_pc_o held constant; no new request issued; the next request uses PC+4 after ready.
- redirect_i with redirect_pc_i=0x200 while in WAIT → DRAIN; the stale rvalid data is not presented; next imem_addr_o=0x200. The same redirect with target 0x202 → fetch_fault_o pulse and next address 0x100.
- trap_i and redirect_i asserted in the same cycle → next address = TRAP_VEC (0x100).
- No rvalid for MAX_WAIT cycles → fetch_fault_o pulses once; late rvalid discarded; next request to 0x100.
- rst_ni asserted mid-WAIT → outputs reset immediately with no clock; after release, the first request goes to RESET_VEC; PC at 0xFFFF_FFFC with ready → next address 0x0 (wrap).

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch sequencer for the RV32I core.
// One outstanding imem transaction at a time; trap > redirect > timeout > halt.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i,
  input  logic        halt_i,
  output logic        fetch_fault_o,
  output logic [31:0] pc_o
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [7:0]  r_cnt;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_fault;

  logic [2:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic [7:0]  w_cnt_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_instr_pc_next;
  logic        w_fault_next;
  logic        w_timeout;
  logic        w_misaligned;
  logic        w_in_flight;

  assign w_timeout    = (r_state == S_WAIT) && !imem_rvalid_i && (r_cnt == LP_MAX_WAIT);
  assign w_misaligned = (redirect_pc_i[1:0] != 2'b00);
  // A response is still owed if the flush hits before it arrives (or as it is granted).
  assign w_in_flight  = ((r_state == S_WAIT)  && !imem_rvalid_i) ||
                        ((r_state == S_DRAIN) && !imem_rvalid_i) ||
                        ((r_state == S_REQ)   && imem_gnt_i);

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_cnt_next      = r_cnt;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_fault_next    = 1'b0;

    if (r_state == S_BOOT) begin
      w_state_next = S_REQ;
    end else if (trap_i || redirect_i) begin
      if (trap_i) begin
        w_pc_next = TRAP_VEC;
      end else if (w_misaligned) begin
        w_pc_next    = TRAP_VEC;
        w_fault_next = 1'b1;
      end else begin
        w_pc_next = redirect_pc_i;
      end
      w_state_next = w_in_flight ? S_DRAIN : S_REQ;
      w_cnt_next   = 8'd0;
    end else if (w_timeout) begin
      w_fault_next = 1'b1;
      w_pc_next    = TRAP_VEC;
      w_state_next = S_DRAIN;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_gnt_i) begin
            w_state_next = S_WAIT;
            w_cnt_next   = 8'd0;
          end else if (halt_i) begin
            w_state_next = S_HALTED;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            w_instr_next    = imem_rdata_i;
            w_instr_pc_next = r_pc;
            w_state_next    = S_HOLD;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (instr_ready_i) begin
            w_pc_next    = r_pc + 32'd4;
            w_state_next = halt_i ? S_HALTED : S_REQ;
          end
        end
        S_DRAIN: begin
          // Counter keeps running for visibility but saturates; timeout is not re-armed here.
          if (imem_rvalid_i) begin
            w_state_next = S_REQ;
          end else if (r_cnt != 8'hFF) begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_HALTED: begin
          if (!halt_i) begin
            w_state_next = S_REQ;
          end
        end
        default: begin
          w_state_next = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VEC;
      r_cnt      <= 8'd0;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_cnt      <= w_cnt_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_fault    <= w_fault_next;
    end
  end

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (r_state == S_HOLD);
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign fetch_fault_o = r_fault;
  assign pc_o          = r_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: drives/samples on the falling edge,
// expected instructions go into a scoreboard queue at grant time and are popped on handshake.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        trap_i;
  logic        halt_i;
  logic        fetch_fault_o;
  logic [31:0] pc_o;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  pc_fetch_ctrl #(
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100),
    .MAX_WAIT (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .trap_i       (trap_i),
    .halt_i       (halt_i),
    .fetch_fault_o(fetch_fault_o),
    .pc_o         (pc_o)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!imem_req_o && n < 40) begin
      cycle();
      n++;
    end
    check("req_seen", {31'd0, imem_req_o}, 32'd1);
  endtask

  // Grant, return data one cycle later, hold for hold_n cycles, then accept.
  task automatic fetch_one(input logic [31:0] exp_addr, input int hold_n, input bit chk_gap);
    int   n;
    exp_t e;
    wait_req(n);
    if (chk_gap) check("b2b_gap", n, 32'd0);
    check("req_addr", imem_addr_o, exp_addr);
    imem_gnt_i = 1'b1;
    sb_q.push_back('{data: mem_data(exp_addr), pc: exp_addr});
    cycle();
    imem_gnt_i = 1'b0;
    check("wait_noreq", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = mem_data(exp_addr);
    cycle();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0BAD_0BAD;
    check("valid_up", {31'd0, instr_valid_o}, 32'd1);
    for (int i = 0; i < hold_n; i++) begin
      check("hold_instr", instr_o, sb_q[0].data);
      check("hold_pc", instr_pc_o, sb_q[0].pc);
      check("hold_noreq", {31'd0, imem_req_o}, 32'd0);
      cycle();
    end
    check("valid_held", {31'd0, instr_valid_o}, 32'd1);
    check("sb_nonempty", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("instr", instr_o, e.data);
      check("instr_pc", instr_pc_o, e.pc);
    end
    instr_ready_i = 1'b1;
    cycle();
    instr_ready_i = 1'b0;
  endtask

  // Issue a request at exp_addr, grant it, and fire a flush while in WAIT.
  task automatic flush_in_wait(input logic [31:0] exp_addr, input logic trap, input logic [31:0] tgt,
                               input logic [31:0] exp_pc, input logic exp_fault);
    int n;
    wait_req(n);
    check("flush_req_addr", imem_addr_o, exp_addr);
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i    = 1'b0;
    trap_i        = trap;
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    cycle();
    trap_i     = 1'b0;
    redirect_i = 1'b0;
    check("flush_fault", {31'd0, fetch_fault_o}, {31'd0, exp_fault});
    check("flush_pc", pc_o, exp_pc);
    check("drain_novalid", {31'd0, instr_valid_o}, 32'd0);
    check("drain_noreq", {31'd0, imem_req_o}, 32'd0);
    cycle();
    check("fault_one_cycle", {31'd0, fetch_fault_o}, 32'd0);
    check("drain_noreq2", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    cycle();
    imem_rvalid_i = 1'b0;
    check("stale_dropped", {31'd0, instr_valid_o}, 32'd0);
    check("post_drain_req", {31'd0, imem_req_o}, 32'd1);
    check("post_drain_addr", imem_addr_o, exp_pc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    rst_ni        = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    trap_i        = 1'b0;
    halt_i        = 1'b0;

    // Reset state
    cycle();
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault_o}, 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_instr_pc", instr_pc_o, 32'h0);
    cycle();
    rst_ni = 1'b1;

    // Sequential fetch at 3-cycle spacing, then a stalled HOLD
    fetch_one(32'h0, 0, 1'b0);
    fetch_one(32'h4, 0, 1'b1);
    fetch_one(32'h8, 0, 1'b1);
    fetch_one(32'hC, 5, 1'b1);
    fetch_one(32'h10, 0, 1'b1);

    // Redirect in WAIT: aligned, then misaligned
    flush_in_wait(32'h14, 1'b0, 32'h200, 32'h200, 1'b0);
    fetch_one(32'h200, 0, 1'b1);
    flush_in_wait(32'h204, 1'b0, 32'h202, 32'h100, 1'b1);
    fetch_one(32'h100, 0, 1'b1);

    // Trap and redirect together: trap wins, no fault
    flush_in_wait(32'h104, 1'b1, 32'h300, 32'h100, 1'b0);
    fetch_one(32'h100, 0, 1'b1);

    // Fetch timeout
    wait_req(n);
    check("to_req_addr", imem_addr_o, 32'h104);
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i = 1'b0;
    n = 0;
    while (!fetch_fault_o && n < 300) begin
      check("to_novalid", {31'd0, instr_valid_o}, 32'd0);
      cycle();
      n++;
    end
    check("to_fault_seen", {31'd0, fetch_fault_o}, 32'd1);
    check("to_pc", pc_o, 32'h100);
    check("to_noreq", {31'd0, imem_req_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (fetch_fault_o) pulses++;
      check("to_drain_noreq", {31'd0, imem_req_o}, 32'd0);
    end
    check("to_single_pulse", pulses, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    cycle();
    imem_rvalid_i = 1'b0;
    check("to_late_dropped", {31'd0, instr_valid_o}, 32'd0);
    check("to_next_addr", imem_addr_o, 32'h100);
    fetch_one(32'h100, 0, 1'b1);

    // Halt in REQ without grant, then resume at the same address
    wait_req(n);
    halt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("halt_noreq", {31'd0, imem_req_o}, 32'd0);
    end
    halt_i = 1'b0;
    cycle();
    check("resume_req", {31'd0, imem_req_o}, 32'd1);
    fetch_one(32'h104, 0, 1'b1);

    // Asynchronous reset in the middle of WAIT
    wait_req(n);
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_req", {31'd0, imem_req_o}, 32'd0);
    check("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("arst_instr", instr_o, 32'h0);
    check("arst_instr_pc", instr_pc_o, 32'h0);
    cycle();
    rst_ni = 1'b1;
    fetch_one(32'h0, 0, 1'b0);

    // PC wrap from 0xFFFF_FFFC
    wait_req(n);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    fetch_one(32'hFFFF_FFFC, 0, 1'b1);
    fetch_one(32'h0, 0, 1'b1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
